// File: rtl/stump_control_if.sv
// Control-side bundle for the Stump control unit: instruction and ALU flags in,
// datapath and memory controls out.
interface stump_control_if;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        fetch;
    logic        execute;
    logic        memory;
    logic        ir_en;
    logic [2:0]  alu_func;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [2:0]  dest;
    logic        reg_write;
    logic        opB_mux_sel;
    logic        ext_op;
    logic [1:0]  shift_op;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  cc;

    // Control unit end: consumes ir/flags, drives everything else.
    modport master (
        input  ir, flags_in,
        output fetch, execute, memory, ir_en, alu_func, srcA, srcB, dest, reg_write,
               opB_mux_sel, ext_op, shift_op, mem_ren, mem_wen, cc
    );

    // Datapath end.
    modport slave (
        output ir, flags_in,
        input  fetch, execute, memory, ir_en, alu_func, srcA, srcB, dest, reg_write,
               opB_mux_sel, ext_op, shift_op, mem_ren, mem_wen, cc
    );
endinterface

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer, instruction decode,
// branch evaluation and the {N,Z,V,C} condition-code register.
module stump_control (
    input  logic            clk,
    input  logic            rst,
    stump_control_if.master bus
);
    typedef enum logic [1:0] {StFetch = 2'd0, StExecute = 2'd1, StMemory = 2'd2} state_t;

    localparam logic [2:0] OpLdSt   = 3'b110;
    localparam logic [2:0] OpBranch = 3'b111;
    localparam logic [2:0] RegPc    = 3'd7;

    state_t     state_q;
    logic [3:0] cc_q;
    logic       cc_en;
    logic       taken;

    // Instruction fields
    logic [2:0] op, rd, ra, rb;
    logic [1:0] sh;
    logic       is_imm, s_bit;
    logic [3:0] cond;

    assign op     = bus.ir[15:13];
    assign is_imm = bus.ir[12];
    assign s_bit  = bus.ir[11];
    assign rd     = bus.ir[10:8];
    assign ra     = bus.ir[7:5];
    assign rb     = bus.ir[4:2];
    assign sh     = bus.ir[1:0];
    assign cond   = bus.ir[11:8];

    assign bus.fetch   = (state_q == StFetch);
    assign bus.execute = (state_q == StExecute);
    assign bus.memory  = (state_q == StMemory);
    assign bus.cc      = cc_q;

    // Branch condition against the current (pre-edge) condition codes.
    always_comb begin
        logic n, z, v, c;
        {n, z, v, c} = cc_q;
        case (cond)
            4'd0:    taken = 1'b1;
            4'd1:    taken = 1'b0;
            4'd2:    taken = ~c & ~z;
            4'd3:    taken = c | z;
            4'd4:    taken = ~c;
            4'd5:    taken = c;
            4'd6:    taken = ~z;
            4'd7:    taken = z;
            4'd8:    taken = ~v;
            4'd9:    taken = v;
            4'd10:   taken = ~n;
            4'd11:   taken = n;
            4'd12:   taken = (n == v);
            4'd13:   taken = (n != v);
            4'd14:   taken = ~z & (n == v);
            default: taken = z | (n != v);
        endcase
    end

    // Output decode from state, instruction and cc; reset suppresses all strobes.
    always_comb begin
        bus.ir_en       = 1'b0;
        bus.alu_func    = 3'b000;
        bus.srcA        = 3'd0;
        bus.srcB        = 3'd0;
        bus.dest        = 3'd0;
        bus.reg_write   = 1'b0;
        bus.opB_mux_sel = 1'b0;
        bus.ext_op      = 1'b0;
        bus.shift_op    = 2'b00;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        cc_en           = 1'b0;
        case (state_q)
            StFetch: begin
                bus.mem_ren   = 1'b1;
                bus.ir_en     = 1'b1;
                bus.reg_write = 1'b1;
                bus.dest      = RegPc;   // PC increment through the datapath
            end
            StExecute: begin
                if (op == OpBranch) begin
                    bus.srcA        = RegPc;
                    bus.opB_mux_sel = 1'b1;
                    bus.ext_op      = 1'b1;
                    bus.dest        = RegPc;
                    bus.reg_write   = taken;
                end else begin
                    // ALU ops and LD/ST address generation share operand routing
                    bus.srcA        = ra;
                    bus.srcB        = rb;
                    bus.opB_mux_sel = is_imm;
                    bus.shift_op    = is_imm ? 2'b00 : sh;
                    if (op != OpLdSt) begin
                        bus.alu_func  = op;
                        bus.dest      = rd;
                        bus.reg_write = 1'b1;
                        cc_en         = s_bit;
                    end
                end
            end
            StMemory: begin
                if (s_bit) begin
                    bus.mem_wen = 1'b1;
                    bus.srcA    = rd;    // store data comes from rd
                end else begin
                    bus.mem_ren   = 1'b1;
                    bus.reg_write = 1'b1;
                    bus.dest      = rd;
                end
            end
            default: ;
        endcase
        if (rst) begin
            bus.reg_write = 1'b0;
            bus.mem_ren   = 1'b0;
            bus.mem_wen   = 1'b0;
            bus.ir_en     = 1'b0;
            cc_en         = 1'b0;
        end
    end

    // Sequencer and condition-code register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cc_q    <= 4'b0000;
        end else begin
            case (state_q)
                StFetch:   state_q <= StExecute;
                StExecute: state_q <= (op == OpLdSt) ? StMemory : StFetch;
                default:   state_q <= StFetch;
            endcase
            if (cc_en) cc_q <= bus.flags_in;
        end
    end
endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: table of instructions plus reset corner cases.
module tb_stump_control;
    logic clk = 1'b0;
    logic rst = 1'b1;

    stump_control_if bus_if ();

    stump_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fetch, execute, memory, ir_en;
        logic [2:0] alu_func, src_a, src_b, dest;
        logic       reg_write, opb, ext_op;
        logic [1:0] shift_op;
        logic       mem_ren, mem_wen;
        logic [3:0] cc;
    } obs_t;

    typedef struct {
        string      name;
        obs_t       exp;
    } sb_t;

    typedef struct {
        string      name;
        logic [15:0] ir;
        logic [3:0] flags;
        logic [3:0] cc_pre;
        obs_t       e_exp;
        obs_t       m_exp;
        bit         has_mem;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    sb_t  sb_q [$];
    int   total = 0;
    int   bad   = 0;
    obs_t obs;

    assign obs = {bus_if.fetch, bus_if.execute, bus_if.memory, bus_if.ir_en,
                  bus_if.alu_func, bus_if.srcA, bus_if.srcB, bus_if.dest,
                  bus_if.reg_write, bus_if.opB_mux_sel, bus_if.ext_op, bus_if.shift_op,
                  bus_if.mem_ren, bus_if.mem_wen, bus_if.cc};

    function automatic obs_t mk(input int fe, input int ex, input int me, input int ire,
                                input int fn, input int a, input int b, input int d,
                                input int rw, input int ob, input int ext, input int sh,
                                input int mr, input int mw, input int c);
        obs_t o;
        o.fetch = fe[0]; o.execute = ex[0]; o.memory = me[0]; o.ir_en = ire[0];
        o.alu_func = fn[2:0]; o.src_a = a[2:0]; o.src_b = b[2:0]; o.dest = d[2:0];
        o.reg_write = rw[0]; o.opb = ob[0]; o.ext_op = ext[0]; o.shift_op = sh[1:0];
        o.mem_ren = mr[0]; o.mem_wen = mw[0]; o.cc = c[3:0];
        return o;
    endfunction

    function automatic obs_t fetch_exp(input int c);
        return mk(1, 0, 0, 1, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, c);
    endfunction

    // Drive one cycle's inputs just after the edge and queue what it should show.
    task automatic run_cycle(input logic r, input logic [15:0] i, input logic [3:0] f,
                             input string name, input obs_t e);
        sb_t s;
        @(posedge clk);
        #1;
        rst = r;
        bus_if.ir = i;
        bus_if.flags_in = f;
        s.name = name;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic run_instr(input vec_t v);
        run_cycle(1'b0, v.ir, v.flags, {v.name, "_F"}, fetch_exp(int'(v.cc_pre)));
        run_cycle(1'b0, v.ir, v.flags, {v.name, "_E"}, v.e_exp);
        if (v.has_mem) run_cycle(1'b0, v.ir, v.flags, {v.name, "_M"}, v.m_exp);
    endtask

    // Scoreboard: compare mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            total++;
            if (obs !== s.exp) begin
                bad++;
                $display("FAIL %s: got %h required %h", s.name, obs, s.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t ld_e;
        ld_e = mk(0, 1, 0, 0, 0, 5, 7, 0, 0, 1, 0, 0, 0, 0, 'b0011);
        vecs[0]  = '{"add_s",    16'h094C, 4'b0101, 4'b0000,
                     mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0000), '0, 1'b0};
        vecs[1]  = '{"add_nos",  16'h014C, 4'b1010, 4'b0101,
                     mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0101), '0, 1'b0};
        vecs[2]  = '{"shift",    16'h432A, 4'b1111, 4'b0101,
                     mk(0, 1, 0, 0, 2, 1, 2, 3, 1, 0, 0, 2, 0, 0, 'b0101), '0, 1'b0};
        vecs[3]  = '{"imm_s",    16'hBEE3, 4'b0011, 4'b0101,
                     mk(0, 1, 0, 0, 5, 7, 0, 6, 1, 1, 0, 0, 0, 0, 'b0101), '0, 1'b0};
        vecs[4]  = '{"ld",       16'hD4BF, 4'b1111, 4'b0011, ld_e,
                     mk(0, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 'b0011), 1'b1};
        vecs[5]  = '{"st",       16'hDCBF, 4'b1111, 4'b0011, ld_e,
                     mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 'b0011), 1'b1};
        vecs[6]  = '{"add_s_z",  16'h094C, 4'b0100, 4'b0011,
                     mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0011), '0, 1'b0};
        vecs[7]  = '{"beq_t",    16'hE7FE, 4'b1111, 4'b0100,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 1, 1, 1, 0, 0, 0, 'b0100), '0, 1'b0};
        vecs[8]  = '{"add_s_0",  16'h094C, 4'b0000, 4'b0100,
                     mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0100), '0, 1'b0};
        vecs[9]  = '{"beq_nt",   16'hE7FE, 4'b1111, 4'b0000,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 0, 1, 1, 0, 0, 0, 'b0000), '0, 1'b0};
        vecs[10] = '{"add_s_nv", 16'h094C, 4'b1010, 4'b0000,
                     mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0000), '0, 1'b0};
        vecs[11] = '{"bgt_t",    16'hEEFE, 4'b0000, 4'b1010,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 1, 1, 1, 0, 0, 0, 'b1010), '0, 1'b0};
        vecs[12] = '{"ble_nt",   16'hEFFE, 4'b0000, 4'b1010,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 0, 1, 1, 0, 0, 0, 'b1010), '0, 1'b0};
        vecs[13] = '{"bnv",      16'hE1FE, 4'b0000, 4'b1010,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 0, 1, 1, 0, 0, 0, 'b1010), '0, 1'b0};
        vecs[14] = '{"bal",      16'hE0FE, 4'b0000, 4'b1010,
                     mk(0, 1, 0, 0, 0, 7, 0, 7, 1, 1, 1, 0, 0, 0, 'b1010), '0, 1'b0};

        bus_if.ir = 16'h0000;
        bus_if.flags_in = 4'b0000;

        // Reset held two cycles: FETCH decode with every strobe suppressed.
        run_cycle(1'b1, 16'h0000, 4'b1111, "rst_0", mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(1'b1, 16'h0000, 4'b1111, "rst_1", mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < NV; k++) run_instr(vecs[k]);

        // Reset during MEMORY of a store: no write strobe, then clean FETCH with cc cleared.
        run_cycle(1'b0, 16'hDCBF, 4'b1111, "rstm_F", fetch_exp('b1010));
        run_cycle(1'b0, 16'hDCBF, 4'b1111, "rstm_E",
                  mk(0, 1, 0, 0, 0, 5, 7, 0, 0, 1, 0, 0, 0, 0, 'b1010));
        run_cycle(1'b1, 16'hDCBF, 4'b1111, "rstm_M",
                  mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 'b1010));
        run_cycle(1'b0, 16'h094C, 4'b1111, "rstm_after", fetch_exp('b0000));

        // Reset during EXECUTE of an S instruction: no register write, no cc update.
        run_cycle(1'b1, 16'h094C, 4'b1111, "rste_E",
                  mk(0, 1, 0, 0, 0, 2, 3, 1, 0, 0, 0, 0, 0, 0, 'b0000));
        run_cycle(1'b0, 16'h094C, 4'b0110, "rste_after", fetch_exp('b0000));
        run_cycle(1'b0, 16'h094C, 4'b0110, "post_E",
                  mk(0, 1, 0, 0, 0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 'b0000));
        run_cycle(1'b0, 16'h014C, 4'b0000, "post_F", fetch_exp('b0110));

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stump_control.md
Name: stump_control

Overview:
Control unit and condition-code register for the Stump 16-bit processor. It is the driving end of the ALU interface and also receives the ALU's flags.
- Drives: ALU function code, register/operand selects, shift and extension controls, register-write and memory strobes.
- Receives: the ALU flags_out bus {N,Z,V,C}, which it latches into the CC register.
- Runs a three-state FETCH/EXECUTE/MEMORY sequencer and evaluates branch conditions against CC.

Parameters:
None.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset; one clock, synchronous, active-high
ir  input  16  current instruction register contents
flags_in  input  4  {N,Z,V,C} from ALU flags_out
fetch  output  1  high in FETCH state
execute  output  1  high in EXECUTE state
memory  output  1  high in MEMORY state
ir_en  output  1  load IR from memory read data
alu_func  output  3  ALU function code
srcA  output  3  register read port A select
srcB  output  3  register read port B select
dest  output  3  register write select
reg_write  output  1  register file write enable
opB_mux_sel  output  1  0 = register B, 1 = sign-extended immediate
ext_op  output  1  0 = extend ir[4:0], 1 = extend ir[7:0]
shift_op  output  2  shifter control to datapath
mem_ren  output  1  memory read strobe
mem_wen  output  1  memory write strobe
cc  output  4  registered condition codes {N,Z,V,C}

Behaviour:
Instruction fields:
- op = ir[15:13]; type = ir[12] (1 = immediate); S = ir[11]; rd = ir[10:8]; ra = ir[7:5]; rb = ir[4:2]; sh = ir[1:0].
- LD/ST is op 110, with ir[11] = 0 for LD and 1 for ST.
- Branch is op 111, with cond = ir[11:8] and offset = ir[7:0].

State machine:
- Registers: 2-bit state and 4-bit cc.
- Transitions: FETCH -> EXECUTE; EXECUTE -> MEMORY if op = 110, else FETCH; MEMORY -> FETCH.
- Reset: on a clock edge with rst = 1, state <= FETCH and cc <= 0000.
- fetch, execute and memory are one-hot decodes of state.

Output decode (combinational from state, ir and cc). Defaults are all 0, except alu_func = 000.
- FETCH:
  - mem_ren = 1, ir_en = 1.
  - reg_write = 1, dest = 7 (PC <= PC+1 via the datapath incrementer).
- EXECUTE, ALU ops (op 000–101):
  - alu_func = op, srcA = ra, srcB = rb, dest = rd, reg_write = 1.
  - opB_mux_sel = type, ext_op = 0.
  - shift_op = sh when type = 0, else 00.
  - cc_en = S.
- EXECUTE, LD/ST:
  - alu_func = 000, srcA = ra, srcB = rb, opB_mux_sel = type.
  - shift_op = sh when type = 0, else 00.
  - reg_write = 0, cc_en = 0.
- EXECUTE, branch:
  - alu_func = 000, srcA = 7, opB_mux_sel = 1, ext_op = 1.
  - dest = 7, reg_write = taken, cc_en = 0.
- MEMORY, LD: mem_ren = 1, reg_write = 1, dest = rd.
- MEMORY, ST: mem_wen = 1, srcA = rd, reg_write = 0.

CC register:
- Update: cc <= flags_in on the edge ending EXECUTE when cc_en = 1; otherwise cc holds.
- cc_en is internal. Flags from a non-S instruction never reach cc.

Branch condition (N, Z, V, C taken from cc):
- 0 AL: 1
- 1 NV: 0
- 2 HI: !C & !Z
- 3 LS: C | Z
- 4 CC: !C
- 5 CS: C
- 6 NE: !Z
- 7 EQ: Z
- 8 VC: !V
- 9 VS: V
- 10 PL: !N
- 11 MI: N
- 12 GE: N == V
- 13 LT: N != V
- 14 GT: !Z & (N == V)
- 15 LE: Z | (N != V)

Boundary rules:
- While rst = 1, reg_write, mem_ren, mem_wen, ir_en and cc_en are forced to 0 in every state.
- Reset asserted in MEMORY or EXECUTE aborts the instruction: no write and no CC update on that edge.
- The branch condition uses cc as it stands before the edge. A preceding S instruction has already updated it.
- op 110/111 are never passed to the ALU as alu_func.
- Reset values: state = FETCH, cc = 0000. Outputs after reset release equal the FETCH decode.

Test Plan:
1. Reset: hold rst = 1 for 2 cycles, then release.
   - During reset: all strobes 0, cc = 0000.
   - First cycle after release: fetch = 1, mem_ren = 1, ir_en = 1, reg_write = 1, dest = 7.
2. ADD R1,R2,R3 with S (ir = 0x094C), flags_in = 0101.
   - EXECUTE: alu_func = 000, srcA = 2, srcB = 3, dest = 1, reg_write = 1, opB_mux_sel = 0.
   - After EXECUTE: cc = 0101, next state FETCH.
   - Same instruction with S = 0 (0x014C): cc unchanged.
3. LD R4,[R5,#-1] (ir = 0xD4BF).
   - States run F, E, M, F.
   - EXECUTE: alu_func = 000, opB_mux_sel = 1, ext_op = 0, reg_write = 0.
   - MEMORY: mem_ren = 1, reg_write = 1, dest = 4.
4. ST R4,[R5,#-1] (ir = 0xDCBF).
   - MEMORY: mem_wen = 1, srcA = 4, reg_write = 0, mem_ren = 0.
5. Branch, EQ (ir = 0xE7FE):
   - cc = 0100: EXECUTE reg_write = 1, dest = 7, srcA = 7, ext_op = 1.
   - cc = 0000: reg_write = 0.
6. Branch, GT (ir = 0xEEFE) with cc = 1010: taken. LE (ir = 0xEFFE) with cc = 1010: not taken.
7. Reset mid-MEMORY: assert rst during MEMORY of the ST in test 4.
   - mem_wen = 0 in that cycle.
   - Next cycle: fetch = 1, cc = 0000.
